// File: rtl/pdm_mic_array_rx_if.sv
// Output frame stream of the PDM mic array receiver: valid/ready with all channels packed per beat.
interface pdm_mic_array_rx_if #(
  parameter int NUM_LINES = 1,
  parameter int OUT_W     = 8
);
  logic                         out_valid;
  logic                         out_ready;
  logic [2*NUM_LINES*OUT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/pdm_mic_array_rx.sv
// Multi-line PDM mic receiver: shared mic clock, dual-edge capture, boxcar decimation to signed PCM frames.
// Optional PDM_MONITOR_EN adds mon_led, a level indicator for channel 0.
module pdm_mic_array_rx #(
  parameter int NUM_LINES     = 1,
  parameter int CLK_DIV       = 4,
  parameter int DECIM         = 64,
  parameter int WARMUP_FRAMES = 2,
  localparam int OUT_W        = $clog2(DECIM) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 pdm_clk,
  input  logic [NUM_LINES-1:0] pdm_data,
  pdm_mic_array_rx_if.master   out_s,
  output logic                 overrun
`ifdef PDM_MONITOR_EN
  ,
  output logic                 mon_led
`endif
);

  localparam int NCH    = 2 * NUM_LINES;
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DECIM);
  localparam int ACC_W  = $clog2(DECIM + 1);
  localparam int WARM_W = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ODD  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIM - 1);

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [BIT_W-1:0]     bitcnt;
  logic [ACC_W-1:0]     acc  [NCH];
  logic [ACC_W-1:0]     ones [NCH];
  logic [OUT_W-1:0]     res  [NCH];
  logic [WARM_W-1:0]    warm;
  logic                 out_valid;
  logic [NCH*OUT_W-1:0] out_data;
  logic                 samp_odd;
  logic                 samp_even;
  logic                 frame_end;
  logic                 warm_done;
  logic                 load;

  always_comb begin
    samp_odd  = en && (cnt == CNT_ODD);
    samp_even = en && (cnt == CNT_LAST);
    frame_end = samp_even && (bitcnt == BIT_LAST);
    cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    warm_done = int'(warm) >= WARMUP_FRAMES;
    load      = frame_end && warm_done && (!out_valid || out_s.out_ready);
    // Even channels take their last bit in the frame-end cycle itself, so fold it in here.
    for (int k = 0; k < NUM_LINES; k++) begin
      ones[2*k]   = acc[2*k] + (pdm_data[k] ? ACC_W'(1) : ACC_W'(0));
      ones[2*k+1] = acc[2*k+1];
    end
    for (int c = 0; c < NCH; c++) begin
      res[c] = (OUT_W'(ones[c]) << 1) - OUT_W'(DECIM);
    end
  end

`ifdef PDM_MONITOR_EN
  int  r0;
  logic mon_hit;
  always_comb begin
    r0      = 2 * int'(ones[0]) - DECIM;
    mon_hit = (r0 >= DECIM / 2) || (-r0 >= DECIM / 2);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bitcnt    <= '0;
      pdm_clk   <= 1'b0;
      warm      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
`ifdef PDM_MONITOR_EN
      mon_led   <= 1'b0;
`endif
    end else begin
      if (!en) begin
        cnt     <= '0;
        bitcnt  <= '0;
        pdm_clk <= 1'b0;
        warm    <= '0;
        for (int c = 0; c < NCH; c++) acc[c] <= '0;
      end else begin
        cnt     <= cnt_nxt;
        pdm_clk <= int'(cnt_nxt) >= CLK_DIV / 2;
        if (cnt == CNT_LAST) bitcnt <= frame_end ? '0 : bitcnt + BIT_W'(1);
        if (frame_end && !warm_done) warm <= warm + WARM_W'(1);
        for (int k = 0; k < NUM_LINES; k++) begin
          if (frame_end) begin
            acc[2*k]   <= '0;
            acc[2*k+1] <= '0;
          end else begin
            if (samp_odd && pdm_data[k])  acc[2*k+1] <= acc[2*k+1] + ACC_W'(1);
            if (samp_even && pdm_data[k]) acc[2*k]   <= acc[2*k] + ACC_W'(1);
          end
        end
      end

      // Stream side runs regardless of en so a pending frame survives a stop.
      if (load) begin
        out_valid <= 1'b1;
        for (int c = 0; c < NCH; c++) out_data[c*OUT_W +: OUT_W] <= res[c];
`ifdef PDM_MONITOR_EN
        mon_led <= mon_hit;
`endif
      end else begin
        if (frame_end && warm_done) overrun <= 1'b1;
        if (out_valid && out_s.out_ready) out_valid <= 1'b0;
      end
    end
  end

  assign out_s.out_valid = out_valid;
  assign out_s.out_data  = out_data;

endmodule

// File: tb/tb_pdm_mic_array_rx.sv
// Directed/randomized bench for pdm_mic_array_rx against a time-since-enable frame model.
module tb_pdm_mic_array_rx;
  localparam int NL  = 1;
  localparam int CD  = 4;
  localparam int DC  = 8;
  localparam int WU  = 2;
  localparam int OW  = $clog2(DC) + 2;
  localparam int NCH = 2 * NL;
  localparam int FP  = CD * DC;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pdm_clk;
  logic [NL-1:0] pdm_data;
  logic          overrun;
`ifdef PDM_MONITOR_EN
  logic          mon_led;
`endif

  pdm_mic_array_rx_if #(.NUM_LINES(NL), .OUT_W(OW)) s_if ();

  pdm_mic_array_rx #(
    .NUM_LINES(NL), .CLK_DIV(CD), .DECIM(DC), .WARMUP_FRAMES(WU)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pdm_clk  (pdm_clk),
    .pdm_data (pdm_data),
    .out_s    (s_if),
    .overrun  (overrun)
`ifdef PDM_MONITOR_EN
    ,
    .mon_led  (mon_led)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycles since enable, frames seen, ones per channel, one-deep output slot.
  int               m_t;
  int               m_frames;
  int               m_ones [NCH];
  logic             m_valid;
  logic             m_ov;
  logic             m_pclk;
  logic [NCH*OW-1:0] m_data;
  logic             m_mon;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rdy, input logic [NL-1:0] d);
    logic loaded;
    logic accepted;
    int   v;
    rst = r; en = e; s_if.out_ready = rdy; pdm_data = d;
    loaded   = 1'b0;
    accepted = m_valid && rdy;
    if (r) begin
      m_t = 0; m_frames = 0; m_valid = 1'b0; m_ov = 1'b0; m_data = '0; m_mon = 1'b0;
      for (int c = 0; c < NCH; c++) m_ones[c] = 0;
    end else begin
      if (e) begin
        for (int k = 0; k < NL; k++) begin
          if (m_t % CD == CD / 2 - 1 && d[k]) m_ones[2*k+1]++;
          if (m_t % CD == CD - 1 && d[k])     m_ones[2*k]++;
        end
        if (m_t % FP == FP - 1) begin
          m_frames++;
          if (m_frames > WU) begin
            if (!m_valid || rdy) begin
              for (int c = 0; c < NCH; c++) m_data[c*OW +: OW] = OW'(2 * m_ones[c] - DC);
              v = 2 * m_ones[0] - DC;
              m_mon   = (v >= DC / 2) || (-v >= DC / 2);
              m_valid = 1'b1;
              loaded  = 1'b1;
            end else begin
              m_ov = 1'b1;
            end
          end
          for (int c = 0; c < NCH; c++) m_ones[c] = 0;
        end
        m_t++;
      end else begin
        m_t = 0; m_frames = 0;
        for (int c = 0; c < NCH; c++) m_ones[c] = 0;
      end
      if (!loaded && accepted) m_valid = 1'b0;
    end
    m_pclk = (!r && e) ? (m_t % CD >= CD / 2) : 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(s_if.out_valid), 32'(m_valid));
    chk("out_data", 32'(s_if.out_data), 32'(m_data));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("pdm_clk", 32'(pdm_clk), 32'(m_pclk));
`ifdef PDM_MONITOR_EN
    chk("mon_led", 32'(mon_led), 32'(m_mon));
`endif
  endtask

  // Steps with en=1, ready=1 and constant data until a frame appears; bounded.
  task automatic wait_first(input logic [NL-1:0] d, output int lat);
    lat = 0;
    for (int i = 0; i < 4 * FP; i++) begin
      step(1'b0, 1'b1, 1'b1, d);
      lat++;
      if (s_if.out_valid) break;
    end
  endtask

  int                lat;
  logic [NCH*OW-1:0] held;

  initial begin
    rst = 1'b1; en = 1'b0; pdm_data = '0; s_if.out_ready = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b1, '0);

    // All ones: first frame after warm-up, both channels full scale positive.
    wait_first(1'b1, lat);
    chk("first_latency", 32'(lat), 32'(FP * (WU + 1)));
    chk("all_ones", 32'(s_if.out_data), 32'({5'b01000, 5'b01000}));
    repeat (2 * FP) step(1'b0, 1'b1, 1'b1, 1'b1);

    repeat (3 * FP) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("all_zeros", 32'(s_if.out_data), 32'({5'b11000, 5'b11000}));

    // Ones only before the falling edge feed channel 0; only before the rising edge feed channel 1.
    repeat (2 * FP) step(1'b0, 1'b1, 1'b1, NL'(m_t % CD == CD - 1));
    chk("even_only", 32'(s_if.out_data), 32'({5'b11000, 5'b01000}));
    repeat (2 * FP) step(1'b0, 1'b1, 1'b1, NL'(m_t % CD == CD / 2 - 1));
    chk("odd_only", 32'(s_if.out_data), 32'({5'b01000, 5'b11000}));

    // Stop mid-frame, then restart: warm-up repeats in full.
    repeat (14) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("stop_pdm_clk", 32'(pdm_clk), 32'(0));
    repeat (60) step(1'b0, 1'b0, 1'b1, NL'($urandom));
    wait_first(1'b1, lat);
    chk("restart_latency", 32'(lat), 32'(FP * (WU + 1)));

    // Backpressure: next frame is dropped and flagged, held frame untouched.
    held = s_if.out_data;
    repeat (70) step(1'b0, 1'b1, 1'b0, NL'($urandom));
    chk("overrun_set", 32'(overrun), 32'(1));
    chk("held_frame", 32'(s_if.out_data), 32'(held));

    for (int i = 0; i < 12 * FP; i++) step(1'b0, 1'b1, 1'(($urandom % 4) != 0), NL'($urandom));
    chk("overrun_sticky", 32'(overrun), 32'(1));

    // Reset mid-frame clears everything, including the sticky flag.
    repeat (13) step(1'b0, 1'b1, 1'b1, NL'($urandom));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_valid", 32'(s_if.out_valid), 32'(0));
    for (int i = 0; i < 8 * FP; i++) step(1'b0, 1'b1, 1'b1, NL'($urandom));
    for (int i = 0; i < 6 * FP; i++) step(1'b0, 1'($urandom % 8 != 0), 1'($urandom % 2), NL'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
